// File: rtl/dump_arbiter_if.sv
// Bundle of trigger, byte-stream and status signals between the TDC frame serializers,
// the dump arbiter and the RAM dump manager.
interface dump_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int CNT_W = 16
);
  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   ch_wen;
  logic [8*NREQ-1:0] ch_data;
  logic              dumpdone;
  logic              dumpMem;
  logic              write_En_datachannel;
  logic [7:0]        data_datachannel;
  logic [NREQ-1:0]   grant;
  logic              busy;
  logic [NREQ-1:0]   pending;
  logic [CNT_W-1:0]  drop_count;
  logic              timeout_flag;

  modport master (
    output req, ch_wen, ch_data, dumpdone,
    input  dumpMem, write_En_datachannel, data_datachannel, grant, busy, pending,
           drop_count, timeout_flag
  );

  modport slave (
    input  req, ch_wen, ch_data, dumpdone,
    output dumpMem, write_En_datachannel, data_datachannel, grant, busy, pending,
           drop_count, timeout_flag
  );
endinterface

// File: rtl/dump_arbiter.sv
// Round-robin arbiter sharing the RAM-dump datapath between NREQ trigger sources.
// Define DUMP_ARB_TIMEOUT_EN to build in the WAIT-state watchdog and sticky timeout_flag.
module dump_arbiter #(
  parameter int NREQ           = 4,
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CNT_W          = 16
) (
  input logic           SYSCLK,
  input logic           reset_n,
  dump_arbiter_if.slave bus
);
  localparam int IDX_W = $clog2(NREQ);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam int SUM_W = CNT_W + 4;
  localparam logic [CNT_W-1:0] DROP_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_GAP} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] sel_q, sel_d;
  logic [NREQ-1:0]  pending_q, pending_d;
  logic [NREQ-1:0]  grant_q, grant_d;
  logic             dump_mem_q, dump_mem_d;
  logic             wen_q, wen_d;
  logic [7:0]       data_q, data_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic [GAP_W-1:0] gap_q, gap_d;

  logic [IDX_W-1:0] rr_sel;
  logic [NREQ-1:0]  clear;
  logic [NREQ-1:0]  dropped;
  logic [SUM_W-1:0] drop_sum;
  logic [7:0]       ch_byte [NREQ];

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_byte
      assign ch_byte[gi] = bus.ch_data[8*gi +: 8];
    end
  endgenerate

  // First pending source strictly after ptr, wrapping around.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NREQ-1:0] pend,
                                               input logic [IDX_W-1:0] ptr);
    logic [IDX_W-1:0] pick;
    logic             found;
    int               idx;
    pick  = ptr;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && pend[idx]) begin
        found = 1'b1;
        pick  = IDX_W'(idx);
      end
    end
    return pick;
  endfunction

`ifdef DUMP_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] wd_q, wd_d;
  logic            tflag_q, tflag_d;
`endif

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    sel_d      = sel_q;
    grant_d    = grant_q;
    gap_d      = gap_q;
    dump_mem_d = 1'b0;
    wen_d      = 1'b0;
    data_d     = 8'h00;
    clear      = '0;
    rr_sel     = rr_pick(pending_q, ptr_q);
`ifdef DUMP_ARB_TIMEOUT_EN
    wd_d       = wd_q;
    tflag_d    = tflag_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (|pending_q) begin
          sel_d          = rr_sel;
          grant_d        = '0;
          grant_d[rr_sel] = 1'b1;
          dump_mem_d     = 1'b1;
          state_d        = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        clear[sel_q] = 1'b1;
        ptr_d        = sel_q;
        state_d      = ST_WAIT;
`ifdef DUMP_ARB_TIMEOUT_EN
        wd_d         = '0;
`endif
      end
      ST_WAIT: begin
        if (bus.dumpdone) begin
          state_d = ST_GAP;
          grant_d = '0;
          gap_d   = '0;
        end
`ifdef DUMP_ARB_TIMEOUT_EN
        else if (wd_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          // Aborted dump is not re-queued; its pending bit was already cleared.
          tflag_d = 1'b1;
          state_d = ST_GAP;
          grant_d = '0;
          gap_d   = '0;
        end else begin
          wd_d = wd_q + 1'b1;
        end
`endif
      end
      ST_GAP: begin
        if (gap_q == GAP_W'(GAP_CYCLES - 1)) state_d = ST_IDLE;
        else gap_d = gap_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_q == ST_ISSUE || state_q == ST_WAIT) begin
      wen_d  = bus.ch_wen[sel_q];
      data_d = ch_byte[sel_q];
    end

    busy_d = (state_d != ST_IDLE);

    // A request coinciding with its own grant re-arms pending rather than dropping.
    dropped   = bus.req & pending_q & ~clear;
    pending_d = (pending_q & ~clear) | bus.req;
    drop_sum  = SUM_W'(drop_q) + SUM_W'($countones(dropped));
    drop_d    = (drop_sum > SUM_W'(DROP_MAX)) ? DROP_MAX : drop_sum[CNT_W-1:0];
  end

  always_ff @(posedge SYSCLK) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      ptr_q      <= IDX_W'(NREQ - 1);
      sel_q      <= '0;
      pending_q  <= '0;
      grant_q    <= '0;
      dump_mem_q <= 1'b0;
      wen_q      <= 1'b0;
      data_q     <= 8'h00;
      busy_q     <= 1'b0;
      drop_q     <= '0;
      gap_q      <= '0;
`ifdef DUMP_ARB_TIMEOUT_EN
      wd_q       <= '0;
      tflag_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      sel_q      <= sel_d;
      pending_q  <= pending_d;
      grant_q    <= grant_d;
      dump_mem_q <= dump_mem_d;
      wen_q      <= wen_d;
      data_q     <= data_d;
      busy_q     <= busy_d;
      drop_q     <= drop_d;
      gap_q      <= gap_d;
`ifdef DUMP_ARB_TIMEOUT_EN
      wd_q       <= wd_d;
      tflag_q    <= tflag_d;
`endif
    end
  end

  assign bus.dumpMem              = dump_mem_q;
  assign bus.write_En_datachannel = wen_q;
  assign bus.data_datachannel     = data_q;
  assign bus.grant                = grant_q;
  assign bus.busy                 = busy_q;
  assign bus.pending              = pending_q;
  assign bus.drop_count           = drop_q;
`ifdef DUMP_ARB_TIMEOUT_EN
  assign bus.timeout_flag         = tflag_q;
`else
  // Always low without the watchdog; the comparison only keeps TIMEOUT_CYCLES referenced.
  assign bus.timeout_flag         = (TIMEOUT_CYCLES < 1);
`endif
endmodule

// File: tb/tb_dump_arbiter.sv
// Self-checking bench for dump_arbiter: a cycle table, directed corner sequences and a
// randomized run compared against an event/timestamp reference model.
module tb_dump_arbiter;
  localparam int N    = 4;
  localparam int GAP  = 4;
  localparam int CW   = 4;
  localparam int DMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  dump_arbiter_if #(.NREQ(N), .CNT_W(CW)) bus ();

  dump_arbiter #(.NREQ(N), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(4096), .CNT_W(CW)) dut (
    .SYSCLK  (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic       dd;
    logic [3:0] wen;
    logic [3:0] e_grant;
    logic       e_dm;
    logic       e_busy;
    logic [3:0] e_pend;
    logic       e_wen;
    logic [7:0] e_data;
    logic [3:0] e_drop;
  } vec_t;

  vec_t tbl [14];

  // reference model state: timestamps instead of FSM states
  logic [3:0] m_pend, r_req, r_wen, clr, dropped, e_grant;
  logic [31:0] r_data;
  logic       r_dd, act, e_wen;
  logic [7:0] e_data;
  int m_last, owner, issue_cyc, free_cyc, m_drop, pick;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.req = '0; bus.dumpdone = 1'b0; bus.ch_wen = '0; bus.ch_data = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    // inputs of cycle n, expected outputs visible during cycle n
    tbl[0]  = '{4'b0001, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 8'h00, 4'd0};
    tbl[1]  = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0001, 1'b0, 8'h00, 4'd0};
    tbl[2]  = '{4'b0100, 1'b1, 4'b0001, 4'b0001, 1'b1, 1'b1, 4'b0001, 1'b0, 8'h00, 4'd0};
    tbl[3]  = '{4'b0100, 1'b0, 4'b0000, 4'b0001, 1'b0, 1'b1, 4'b0100, 1'b1, 8'h3C, 4'd0};
    tbl[4]  = '{4'b0000, 1'b1, 4'b0001, 4'b0001, 1'b0, 1'b1, 4'b0100, 1'b0, 8'h3C, 4'd1};
    tbl[5]  = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 4'b0100, 1'b1, 8'h3C, 4'd1};
    tbl[6]  = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 4'b0100, 1'b0, 8'h00, 4'd1};
    tbl[7]  = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 4'b0100, 1'b0, 8'h00, 4'd1};
    tbl[8]  = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 4'b0100, 1'b0, 8'h00, 4'd1};
    tbl[9]  = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0100, 1'b0, 8'h00, 4'd1};
    tbl[10] = '{4'b0000, 1'b0, 4'b0100, 4'b0100, 1'b1, 1'b1, 4'b0100, 1'b0, 8'h00, 4'd1};
    tbl[11] = '{4'b0000, 1'b1, 4'b0000, 4'b0100, 1'b0, 1'b1, 4'b0000, 1'b1, 8'hA5, 4'd1};
    tbl[12] = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 8'hA5, 4'd1};
    tbl[13] = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 8'h00, 4'd1};

    // ---- table-driven sequence ----
    do_reset();
    chk("reset_timeout_flag", bus.timeout_flag, 1'b0);
    for (int i = 0; i < 14; i++) begin
      chk($sformatf("tbl%0d_grant", i),   bus.grant,                tbl[i].e_grant);
      chk($sformatf("tbl%0d_dumpMem", i), bus.dumpMem,              tbl[i].e_dm);
      chk($sformatf("tbl%0d_busy", i),    bus.busy,                 tbl[i].e_busy);
      chk($sformatf("tbl%0d_pending", i), bus.pending,              tbl[i].e_pend);
      chk($sformatf("tbl%0d_wen", i),     bus.write_En_datachannel, tbl[i].e_wen);
      chk($sformatf("tbl%0d_data", i),    bus.data_datachannel,     tbl[i].e_data);
      chk($sformatf("tbl%0d_drop", i),    bus.drop_count,           tbl[i].e_drop);
      bus.req = tbl[i].req; bus.dumpdone = tbl[i].dd; bus.ch_wen = tbl[i].wen;
      bus.ch_data = 32'h44A5_223C;
      @(negedge clk);
      $display("tbl row %0d applied", i);
    end

    // ---- long wait then dumpdone: release after GAP+1 cycles ----
    do_reset();
    bus.req = 4'b0001; @(negedge clk); bus.req = '0; @(negedge clk);
    chk("t1_dumpMem", bus.dumpMem, 1'b1);
    chk("t1_grant", bus.grant, 4'b0001);
    repeat (300) @(negedge clk);
    chk("t1_hold_grant", bus.grant, 4'b0001);
    bus.dumpdone = 1'b1; @(negedge clk); bus.dumpdone = 1'b0;
    chk("t1_grant_drop", bus.grant, 4'b0000);
    repeat (GAP - 1) @(negedge clk);
    chk("t1_busy_last_gap", bus.busy, 1'b1);
    @(negedge clk);
    chk("t1_busy_idle", bus.busy, 1'b0);
    $display("seq long-wait done");

    // ---- reset mid-WAIT discards pending and rr pointer ----
    do_reset();
    bus.req = 4'b0001; @(negedge clk); bus.req = '0; @(negedge clk); @(negedge clk);
    bus.req = 4'b1010; bus.ch_wen = 4'b1111; bus.ch_data = 32'hFFFF_FFFF;
    @(negedge clk); bus.req = '0;
    chk("t6_pending_before", bus.pending, 4'b1010);
    chk("t6_wen_before", bus.write_En_datachannel, 1'b1);
    reset_n = 1'b0; @(negedge clk);
    chk("t6_grant", bus.grant, 4'b0000);
    chk("t6_pending", bus.pending, 4'b0000);
    chk("t6_busy", bus.busy, 1'b0);
    chk("t6_wen", bus.write_En_datachannel, 1'b0);
    chk("t6_data", bus.data_datachannel, 8'h00);
    reset_n = 1'b1; idle_inputs(); bus.req = 4'b1001;
    @(negedge clk); bus.req = '0; @(negedge clk);
    chk("t6_dumpMem_after", bus.dumpMem, 1'b1);
    chk("t6_first_grant", bus.grant, 4'b0001);
    $display("seq reset-mid-wait done");

    // ---- no dumpdone: without the watchdog the dump never ends ----
    do_reset();
    bus.req = 4'b0001; @(negedge clk); bus.req = '0;
    repeat (10000) @(negedge clk);
    chk("t5_busy_stuck", bus.busy, 1'b1);
    chk("t5_grant_stuck", bus.grant, 4'b0001);
    chk("t5_timeout_flag", bus.timeout_flag, 1'b0);
    $display("seq no-dumpdone done");

    // ---- randomized run against the reference model ----
    do_reset();
    m_pend = '0; m_last = N - 1; owner = -1; issue_cyc = 0; free_cyc = 0; m_drop = 0;
    e_wen = 1'b0; e_data = 8'h00;
    for (int n = 0; n < 4000; n++) begin
      act     = (owner >= 0) && (n >= issue_cyc);
      e_grant = act ? 4'(1 << owner) : 4'b0000;
      chk("rnd_grant",   bus.grant, e_grant);
      chk("rnd_dumpMem", bus.dumpMem, (owner >= 0) && (n == issue_cyc));
      chk("rnd_busy",    bus.busy, act || ((owner < 0) && (n < free_cyc)));
      chk("rnd_pending", bus.pending, m_pend);
      chk("rnd_drop",    bus.drop_count, m_drop);
      chk("rnd_wen",     bus.write_En_datachannel, e_wen);
      chk("rnd_data",    bus.data_datachannel, e_data);
      chk("rnd_tflag",   bus.timeout_flag, 1'b0);

      r_req = '0;
      for (int b = 0; b < N; b++) if ($urandom_range(9) == 0) r_req[b] = 1'b1;
      r_wen  = 4'($urandom);
      r_data = $urandom;
      r_dd   = (act && n > issue_cyc) ? ($urandom_range(3) == 0) : ($urandom_range(19) == 0);

      if (act) begin
        e_wen = r_wen[owner]; e_data = r_data[owner*8 +: 8];
      end else begin
        e_wen = 1'b0; e_data = 8'h00;
      end
      clr     = ((owner >= 0) && (n == issue_cyc)) ? 4'(1 << owner) : 4'b0000;
      dropped = r_req & m_pend & ~clr;
      m_drop  = m_drop + $countones(dropped);
      if (m_drop > DMAX) m_drop = DMAX;
      if ((owner >= 0) && (n > issue_cyc) && r_dd) begin
        owner = -1; free_cyc = n + GAP + 1;
      end else if ((owner < 0) && (n >= free_cyc) && (m_pend != 0)) begin
        pick = -1;
        for (int k = 1; k <= N; k++)
          if (pick < 0 && m_pend[(m_last + k) % N]) pick = (m_last + k) % N;
        owner = pick; issue_cyc = n + 1; m_last = pick;
        $display("rnd grant to source %0d at cycle %0d", pick, n + 1);
      end
      m_pend = (m_pend & ~clr) | r_req;

      bus.req = r_req; bus.ch_wen = r_wen; bus.ch_data = r_data; bus.dumpdone = r_dd;
      @(negedge clk);
    end
    idle_inputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
